// File: rtl/serial_framer_pkg.sv
// Shared definitions for the serial framer.
//   serial_framer_state_t : FSM state encoding
//   LINE_IDLE             : level of the serial line between frames
package serial_framer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } serial_framer_state_t;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data (data_o is the head word
// whenever empty_o is low).
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-high reset (empties FIFO)
//   push_i / data_i   : write request and word; ignored while full
//   pop_i  / data_o   : read request and head word; ignored while empty
//   full_o, empty_o   : occupancy flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign data_o  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/serial_framer.sv
// Parallel-to-serial framer: buffers WIDTH-bit words and sends each as
// start(0), WIDTH data bits LSB first, [even parity], stop(1), every bit
// held CLKS_PER_BIT cycles. Frames run back-to-back while words are queued.
// Optional feature: define SERIAL_FRAMER_PARITY_EN to add the parity bit.
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   valid_i, data_i   : upstream word, accepted when valid_i && ready_o
//   ready_o           : FIFO has room (low during reset)
//   serial_o          : framed serial line, idle high
//   busy_o            : frame in progress or words buffered
//   done_o            : one-cycle pulse in the last cycle of each stop bit
//
// state    | meaning
// S_IDLE   | line idle, waiting for a buffered word
// S_START  | sending start bit (0)
// S_DATA   | sending payload bits, LSB first
// S_PARITY | sending even parity of payload (parity build only)
// S_STOP   | sending stop bit (1)
module serial_framer
    import serial_framer_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             serial_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // With one clock per bit, the stop bit's first cycle is also its last.
    localparam logic STOP_DONE_NOW = (CLKS_PER_BIT == 1);

    serial_framer_state_t state;
    logic [DIV_W-1:0]     div_cnt;
    logic [CNT_W-1:0]     bit_cnt;
    logic [WIDTH-1:0]     shreg;
    logic [WIDTH-1:0]     fifo_rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 bit_end;
`ifdef SERIAL_FRAMER_PARITY_EN
    logic                 parity_q;
`endif

    assign ready_o   = !fifo_full && !rst_i;
    assign fifo_push = valid_i && ready_o;
    assign bit_end   = (div_cnt == '0);
    assign busy_o    = (state != S_IDLE) || !fifo_empty;
    // Pop in IDLE, or at the end of a stop bit for a gap-free next frame.
    assign fifo_pop  = !fifo_empty &&
                       ((state == S_IDLE) || ((state == S_STOP) && bit_end));

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .data_i  (data_i),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rd_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            serial_o <= LINE_IDLE;
            done_o   <= 1'b0;
`ifdef SERIAL_FRAMER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            if (fifo_pop) begin
                shreg    <= fifo_rd_data;
`ifdef SERIAL_FRAMER_PARITY_EN
                parity_q <= ^fifo_rd_data;
`endif
            end
            case (state)
                S_IDLE: begin
                    if (fifo_pop) begin
                        state    <= S_START;
                        serial_o <= ~LINE_IDLE;
                        div_cnt  <= DIV_LOAD;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state    <= S_DATA;
                        serial_o <= shreg[0];
                        shreg    <= shreg >> 1;
                        bit_cnt  <= BIT_LAST;
                        div_cnt  <= DIV_LOAD;
                    end else begin
                        div_cnt <= div_cnt - DIV_ONE;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        div_cnt <= DIV_LOAD;
                        if (bit_cnt == '0) begin
`ifdef SERIAL_FRAMER_PARITY_EN
                            state    <= S_PARITY;
                            serial_o <= parity_q;
`else
                            state    <= S_STOP;
                            serial_o <= LINE_IDLE;
                            done_o   <= STOP_DONE_NOW;
`endif
                        end else begin
                            serial_o <= shreg[0];
                            shreg    <= shreg >> 1;
                            bit_cnt  <= bit_cnt - CNT_ONE;
                        end
                    end else begin
                        div_cnt <= div_cnt - DIV_ONE;
                    end
                end
`ifdef SERIAL_FRAMER_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        state    <= S_STOP;
                        serial_o <= LINE_IDLE;
                        done_o   <= STOP_DONE_NOW;
                        div_cnt  <= DIV_LOAD;
                    end else begin
                        div_cnt <= div_cnt - DIV_ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        if (fifo_pop) begin
                            state    <= S_START;
                            serial_o <= ~LINE_IDLE;
                            div_cnt  <= DIV_LOAD;
                        end else begin
                            state    <= S_IDLE;
                            serial_o <= LINE_IDLE;
                        end
                    end else begin
                        div_cnt <= div_cnt - DIV_ONE;
                        done_o  <= (div_cnt == DIV_ONE);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    serial_o <= LINE_IDLE;
                    div_cnt  <= '0;
                    bit_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_framer.sv
module tb_serial_framer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CPB   = 4;
`ifdef SERIAL_FRAMER_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int L = NBITS * CPB;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             valid_i;
    logic [WIDTH-1:0] data_i;
    logic             ready_o;
    logic             serial_o;
    logic             busy_o;
    logic             done_o;

    int n_vec = 0;
    int n_err = 0;

    // Expected line samples still to come, one per cycle: {level, done}.
    logic [1:0] line_q[$];

    always #5 clk_i = ~clk_i;

    serial_framer #(
        .WIDTH        (WIDTH),
        .FIFO_DEPTH   (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .data_i   (data_i),
        .ready_o  (ready_o),
        .serial_o (serial_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Whole frame for one word, built straight from the line format.
    function automatic void push_frame(input logic [WIDTH-1:0] w);
        for (int c = 0; c < CPB; c++) line_q.push_back(2'b00);
        for (int i = 0; i < WIDTH; i++)
            for (int c = 0; c < CPB; c++) line_q.push_back({w[i], 1'b0});
`ifdef SERIAL_FRAMER_PARITY_EN
        for (int c = 0; c < CPB; c++) line_q.push_back({^w, 1'b0});
`endif
        for (int c = 0; c < CPB; c++) line_q.push_back({1'b1, c == CPB - 1});
    endfunction

    // Words waiting in the buffer = whole frames not yet started.
    function automatic logic model_ready();
        return (line_q.size() / L) < DEPTH;
    endfunction

    task automatic step(input logic v, input logic [WIDTH-1:0] d, output logic acc);
        logic [1:0] s;
        logic       active;
        valid_i = v;
        data_i  = d;
        acc     = v && model_ready();
        @(posedge clk_i);
        if (line_q.size() > 0) begin
            s      = line_q.pop_front();
            active = 1'b1;
        end else begin
            s      = 2'b10;
            active = 1'b0;
        end
        if (acc) push_frame(d);
        #1;
        check("serial", serial_o, s[1]);
        check("done", done_o, s[0]);
        check("busy", busy_o, active || (line_q.size() > 0));
        check("ready", ready_o, model_ready());
    endtask

    task automatic idle_steps(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, WIDTH'($urandom), a);
    endtask

    task automatic drain();
        int   guard;
        logic a;
        guard = 0;
        while (line_q.size() > 0 && guard < 2000) begin
            step(1'b0, WIDTH'($urandom), a);
            guard++;
        end
        step(1'b0, WIDTH'($urandom), a);
        check("drained_busy", busy_o, 1'b0);
    endtask

    initial begin
        logic acc;
        int   idx;
        int   guard;
        int   rate;

        rst_i   = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        #3;
        check("rst_serial", serial_o, 1'b1);
        check("rst_ready", ready_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        check("ready_after_rst", ready_o, 1'b1);

        // Single frame 8'hA5, then 8'h01 (odd parity payload).
        step(1'b1, 8'hA5, acc);
        check("a5_accepted", acc, 1'b1);
        idle_steps(L + 5);
        step(1'b1, 8'h01, acc);
        idle_steps(L + 5);

        // Six words with valid held high: FIFO fills, frames back-to-back.
        idx   = 0;
        guard = 0;
        while (idx < 6 && guard < 600) begin
            step(1'b1, 8'h10 + 8'(idx), acc);
            if (acc) idx++;
            guard++;
        end
        check("burst_words_accepted", idx, 6);
        drain();

        // Randomized traffic at several offered loads.
        for (int phase = 0; phase < 3; phase++) begin
            rate = (phase == 0) ? 5 : (phase == 1) ? 30 : 90;
            for (int i = 0; i < 250; i++)
                step(($urandom_range(0, 99) < rate), WIDTH'($urandom), acc);
        end
        drain();

        // Reset in the middle of the 8'h3C frame with two words buffered.
        step(1'b1, 8'h3C, acc);
        step(1'b1, WIDTH'($urandom), acc);
        step(1'b1, WIDTH'($urandom), acc);
        idle_steps(11);
        rst_i = 1'b1;
        line_q.delete();
        #1;
        check("midrst_serial", serial_o, 1'b1);
        check("midrst_ready", ready_o, 1'b0);
        check("midrst_busy", busy_o, 1'b0);
        check("midrst_done", done_o, 1'b0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        check("midrst_hold_serial", serial_o, 1'b1);
        rst_i = 1'b0;
        #1;
        check("midrst_ready_rise", ready_o, 1'b1);
        idle_steps(L + 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_framer.md
SERIAL_FRAMER -- requirements
Module: serial_framer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning payload bits per frame (range 1..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning input word buffer entries (power of two, at least 2).
REQ-003 SHALL have parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit (at least 1).
REQ-004 SHALL have port clk_i  input  1  meaning single clock; all logic rising-edge.
REQ-005 SHALL have port rst_i  input  1  meaning reset, asynchronous, active-high.
REQ-006 SHALL have port valid_i  input  1  meaning upstream word valid.
REQ-007 SHALL have port data_i  input  WIDTH  meaning upstream parallel word.
REQ-008 SHALL have port ready_o  output  1  meaning word accepted at an edge where valid_i and ready_o are both high.
REQ-009 SHALL have port serial_o  output  1  meaning framed serial line; idle high.
REQ-010 SHALL have port busy_o  output  1  meaning FSM not in IDLE or FIFO non-empty.
REQ-011 SHALL have port done_o  output  1  meaning one-cycle pulse in the last cycle of each stop bit.

Function
REQ-012 SHALL drive ready_o as !fifo_full only; a pop in the same cycle SHALL NOT raise ready_o.
REQ-013 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; PARITY is reachable only per REQ-024.
REQ-014 SHALL transition IDLE to START at the next edge when the FIFO is non-empty, popping the head word into an internal WIDTH-bit shift register.
REQ-015 SHALL hold each bit for exactly CLKS_PER_BIT cycles via a divider counter that reloads at every bit boundary.
REQ-016 SHALL drive serial_o as follows: START=0; DATA=shift register LSB, shifted right once per bit, WIDTH bits (LSB first); STOP=1; IDLE=1.
REQ-017 SHALL, at the end of STOP, pop and go directly to START if the FIFO is non-empty (no idle bit between frames), else go to IDLE.
REQ-018 SHALL give a latency from a word accepted at edge N (FIFO empty, FSM IDLE) to serial_o low at edge N+1 of exactly one cycle.
REQ-019 SHALL transmit words in acceptance order; with the FIFO empty, push and pop SHALL NOT coincide (the pop occurs at the following edge).
REQ-020 SHALL ignore valid_i while ready_o is low; data_i is don't-care when valid_i is low.
REQ-021 SHALL count data bits with a counter of width $clog2(WIDTH+1); WIDTH=1 SHALL be legal.

Reset
REQ-022 SHALL, while rst_i is high, immediately force: serial_o=1, ready_o=0, busy_o=0, done_o=0, FSM=IDLE, FIFO empty, all counters 0.
REQ-023 SHALL, on reset mid-frame, discard both the partial frame and the buffered words; ready_o SHALL rise in the first cycle after rst_i deasserts.

Configuration
REQ-024 SHALL, with macro SERIAL_FRAMER_PARITY_EN defined, insert a PARITY state between DATA and STOP driving the even-parity bit (XOR of the payload) for CLKS_PER_BIT cycles; without the macro, DATA SHALL go directly to STOP and no parity logic SHALL exist.

Structure
REQ-025 SHALL take its state enum (serial_framer_state_t) and the serial line idle level constant from the shared package serial_framer_pkg.
REQ-026 SHALL instantiate sub-module sync_fifo (WIDTH, FIFO_DEPTH; push/pop/full/empty; same clk_i/rst_i) for buffering; FSM, divider and shift register stay in serial_framer.

Verification (WIDTH=8, CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-027 SHALL cover: push 8'hA5 while idle -> serial_o holds 0,1,0,1,0,0,1,0,1,1, each value for 4 cycles (40 cycles); done_o pulses once in cycle 40; busy_o drops the next cycle.
REQ-028 SHALL cover: with SERIAL_FRAMER_PARITY_EN, push 8'hA5 -> parity bit 0 after the data bits; 44-cycle frame. Push 8'h01 -> parity bit 1.
REQ-029 SHALL cover: hold valid_i high with 6 words 8'h10..8'h15 -> ready_o low while 4 words are buffered; all 6 frames go out in order back-to-back, with no high cycle between a stop bit and the next start bit.
REQ-030 SHALL cover: assert rst_i 13 cycles into the 8'h3C frame with 2 words buffered -> serial_o=1 and ready_o=0 in the same cycle; after release nothing is transmitted, and busy_o=0.
REQ-031 SHALL cover: valid_i high on the same edge the FSM pops from a full FIFO -> the word is not accepted (ready_o low) and is accepted on the next edge.
